fxu_pipe: RTL and testbench
===========================

Name: fxu_pipe

Overview:
- Parametrised fixed-point execution unit for the out-of-order core; successor to the single-cycle FXU.
- Accepts one decoded ALU op per cycle from the reservation station under a valid/ready handshake.
- Carries the ROB tag through a STAGES-deep pipeline and returns the result to the ROB writeback port with backpressure.
- Adds a ROB-driven flush that kills in-flight ops, plus an illegal-opcode flag.

Parameters:
- DATA_W, 16, operand/result width; must be even and >= 4.
- IDX_W, 4, ROB index width.
- STAGES, 2, pipeline register stages from accept to result; must be >= 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  op presented.
- in_ready  out  1  unit can accept this cycle.
- opcode  in  4  operation code.
- in_index  in  IDX_W  ROB index of op.
- vt  in  DATA_W  current value of target register.
- va  in  DATA_W  operand A.
- vb  in  DATA_W  operand B.
- imm  in  DATA_W/2  immediate.
- flush  in  1  kill all in-flight ops (mispredict/exception).
- out_valid  out  1  result valid.
- out_ready  in  1  ROB accepts result.
- out_index  out  IDX_W  ROB index of result.
- out_value  out  DATA_W  result.
- out_illegal  out  1  opcode not recognised; out_value is 0.

Behaviour:
- Opcodes (H = DATA_W/2):
  - 0000 add: va+vb, modulo 2^DATA_W.
  - 0001 sub: va-vb, modulo 2^DATA_W.
  - 0100 mov: va.
  - 0101 movl: {vt[DATA_W-1:H], imm}.
  - 0110 movh: {imm, vt[H-1:0]}.
  - Any other opcode: value 0, illegal=1.
- Result computed combinationally at accept and captured into stage 1 with index and illegal; stages 2..STAGES only shift.
- The last stage drives out_valid, out_index, out_value and out_illegal directly from registers; no combinational path from inputs to outputs.
- Accept: when in_valid && in_ready && !flush.
- Latency: op accepted at edge N is presented at the output after edge N+STAGES-1, with no stall. STAGES=1 gives 1-cycle latency.
- Stall:
  - advance = !out_valid || out_ready.
  - in_ready = advance; it depends only on registered out_valid and on out_ready.
  - On advance, all stages shift one step. Otherwise every stage holds.
  - Bubbles are not collapsed.
- Throughput: 1 op/cycle while out_ready=1.
- Output stability: while out_valid && !out_ready, out_index, out_value and out_illegal hold constant.
- Result retirement: a result is retired in the cycle where out_valid && out_ready.
- Flush (synchronous):
  - All stage valid bits clear at the next edge.
  - An input offered the same cycle is not accepted.
  - A result handshaking that same cycle (out_valid && out_ready) counts as retired.
  - Data/index registers need not clear.
- Reset (asynchronous): all valid bits 0, out_valid=0, out_index=0, out_value=0, out_illegal=0. in_ready=1 whenever out_valid=0.
- Reset mid-operation: in-flight ops are discarded with no output. The first accept after reset deassertion behaves as from idle.
- Simultaneous flush and rst: rst dominates.
- Empty stages carry valid=0 and never produce out_valid.

Test Plan:
- Basic ALU, DATA_W=16, STAGES=2, out_ready=1:
  - add va=0x0005 vb=0x0003 idx=3 -> out_value=0x0008, idx=3, one edge after accept.
  - sub va=0x0000 vb=0x0001 -> 0xFFFF (wrap).
- Immediate moves, vt=0xABCD, imm=0x12:
  - movl -> 0xAB12.
  - movh -> 0x12CD.
  - opcode 1111 -> out_value=0, out_illegal=1.
- Backpressure:
  - Stream 4 adds (idx 0..3) with out_ready=0 from cycle 2.
  - in_ready falls once out_valid=1; idx0 holds stable.
  - Raise out_ready -> idx 0,1,2,3 retire in order, none lost or duplicated.
- Flush:
  - Issue idx 5,6 back to back, then assert flush for 1 cycle with in_valid=1 idx=7.
  - No out_valid for 5,6,7 afterwards.
  - Next op idx=8 returns normally.
- Reset mid-flight: assert rst asynchronously between edges with 2 ops in flight -> outputs 0 immediately, no result after release.
- Parameter sweep:
  - DATA_W=32, IDX_W=6, STAGES=1: add 0xFFFFFFFF+1 -> 0x00000000 at 1-cycle latency, full-rate streaming of 64 ops with out_ready random.
  - Compare against a scoreboard model.

Source files
------------

// File: rtl/fxu_pipe_if.sv
// Handshake bundle between the reservation station / ROB and the pipelined FXU.
// Issue side (in_valid/in_ready) and writeback side (out_valid/out_ready) both use
// valid/ready: a beat transfers on a rising edge where valid && ready are both high;
// a producer holding valid keeps its payload stable until the beat transfers.
// flush is a one-cycle ROB command that kills every op still inside the unit.
interface fxu_pipe_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            opcode;
    logic [IDX_W-1:0]      in_index;
    logic [DATA_W-1:0]     vt;
    logic [DATA_W-1:0]     va;
    logic [DATA_W-1:0]     vb;
    logic [DATA_W/2-1:0]   imm;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [IDX_W-1:0]      out_index;
    logic [DATA_W-1:0]     out_value;
    logic                  out_illegal;

    // Reservation station + ROB side
    modport master (
        output in_valid, opcode, in_index, vt, va, vb, imm, flush, out_ready,
        input  in_ready, out_valid, out_index, out_value, out_illegal
    );

    // Execution unit side
    modport slave (
        input  in_valid, opcode, in_index, vt, va, vb, imm, flush, out_ready,
        output in_ready, out_valid, out_index, out_value, out_illegal
    );
endinterface

// File: rtl/fxu_pipe.sv
// Pipelined fixed-point execution unit. The ALU result is computed at accept and
// captured into stage 0; later stages only shift. The whole pipe advances in
// lock-step whenever the output register is empty or being drained, so bubbles
// are kept rather than collapsed. All outputs come straight from the last stage.
module fxu_pipe #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 4,
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    fxu_pipe_if.slave bus
);
    localparam int H = DATA_W / 2;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MOV  = 4'b0100;
    localparam logic [3:0] OP_MOVL = 4'b0101;
    localparam logic [3:0] OP_MOVH = 4'b0110;

    // Stage storage; index STAGES-1 is the output register
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] ill_q, ill_d;
    logic [DATA_W-1:0] val_q [STAGES];
    logic [DATA_W-1:0] val_d [STAGES];
    logic [IDX_W-1:0]  idx_q [STAGES];
    logic [IDX_W-1:0]  idx_d [STAGES];

    logic              advance;
    logic              accept;
    logic [DATA_W-1:0] res_value;
    logic              res_illegal;

    // The pipe moves only when the output slot is free or retiring this cycle.
    // in_ready therefore depends on registered out_valid and on out_ready only.
    assign advance = !vld_q[STAGES-1] || bus.out_ready;
    assign accept  = bus.in_valid && advance && !bus.flush;

    // ALU: decode opcode and form the result for the op being offered
    always_comb begin
        res_value   = '0;
        res_illegal = 1'b0;
        unique case (bus.opcode)
            OP_ADD:  res_value = bus.va + bus.vb;
            OP_SUB:  res_value = bus.va - bus.vb;
            OP_MOV:  res_value = bus.va;
            OP_MOVL: res_value = {bus.vt[DATA_W-1:H], bus.imm};
            OP_MOVH: res_value = {bus.imm, bus.vt[H-1:0]};
            default: res_illegal = 1'b1;
        endcase
    end

    // Next state: shift every stage on advance, hold otherwise; flush empties the pipe
    always_comb begin
        vld_d = vld_q;
        ill_d = ill_q;
        val_d = val_q;
        idx_d = idx_q;
        if (advance) begin
            vld_d[0] = accept;
            ill_d[0] = res_illegal;
            val_d[0] = res_value;
            idx_d[0] = bus.in_index;
            for (int i = 1; i < STAGES; i++) begin
                vld_d[i] = vld_q[i-1];
                ill_d[i] = ill_q[i-1];
                val_d[i] = val_q[i-1];
                idx_d[i] = idx_q[i-1];
            end
        end
        // A result retiring in the flush cycle has already been handed over;
        // everything still inside is killed. Payload is left as-is.
        if (bus.flush) begin
            vld_d = '0;
        end
    end

    // Stage registers; reset clears everything so the outputs read as zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            ill_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                val_q[i] <= '0;
                idx_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            ill_q <= ill_d;
            val_q <= val_d;
            idx_q <= idx_d;
        end
    end

    assign bus.in_ready    = advance;
    assign bus.out_valid   = vld_q[STAGES-1];
    assign bus.out_index   = idx_q[STAGES-1];
    assign bus.out_value   = val_q[STAGES-1];
    assign bus.out_illegal = ill_q[STAGES-1];

endmodule

// File: tb/tb_fxu_pipe.sv
// Bench for fxu_pipe: a 16-bit/2-stage instance and a 32-bit/1-stage instance
// share one clock and reset. Inputs change 1ns after the rising edge; outputs
// are sampled on the falling edge or 1ns after the rising edge.
module tb_fxu_pipe;
  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   a_retired = 0;
  int   b_retired = 0;

  // Scoreboards hold {illegal, index, value}
  logic [20:0] exp_a_q[$];
  logic [38:0] exp_b_q[$];
  logic [20:0] a_front;
  logic [38:0] b_front;

  fxu_pipe_if #(.DATA_W(16), .IDX_W(4)) a_if();
  fxu_pipe_if #(.DATA_W(32), .IDX_W(6)) b_if();

  fxu_pipe #(.DATA_W(16), .IDX_W(4), .STAGES(2)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
  fxu_pipe #(.DATA_W(32), .IDX_W(6), .STAGES(1)) dut_b (.clk(clk), .rst(rst), .bus(b_if));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [20:0] model_a(logic [3:0] op, logic [3:0] idx, logic [15:0] vt,
                                          logic [15:0] va, logic [15:0] vb, logic [7:0] imm);
    logic [15:0] v;
    logic        ill;
    ill = 1'b0;
    case (op)
      4'h0: v = va + vb;
      4'h1: v = va - vb;
      4'h4: v = va;
      4'h5: v = {vt[15:8], imm};
      4'h6: v = {imm, vt[7:0]};
      default: begin v = 16'h0; ill = 1'b1; end
    endcase
    return {ill, idx, v};
  endfunction

  function automatic logic [38:0] model_b(logic [3:0] op, logic [5:0] idx, logic [31:0] vt,
                                          logic [31:0] va, logic [31:0] vb, logic [15:0] imm);
    logic [31:0] v;
    logic        ill;
    ill = 1'b0;
    case (op)
      4'h0: v = va + vb;
      4'h1: v = va - vb;
      4'h4: v = va;
      4'h5: v = {vt[31:16], imm};
      4'h6: v = {imm, vt[15:0]};
      default: begin v = 32'h0; ill = 1'b1; end
    endcase
    return {ill, idx, v};
  endfunction

  // ---------------- scoreboards ----------------
  // Decisions taken on the falling edge describe what the next rising edge does.
  always @(negedge clk) begin
    if (rst) begin
      exp_a_q.delete();
    end else begin
      if (a_if.out_valid) begin
        checks++;
        if (exp_a_q.size() == 0) begin
          errors++;
          $display("FAIL a_spurious_output got idx=%0d val=%h exp=no result pending", a_if.out_index, a_if.out_value);
        end else if (a_if.out_ready) begin
          a_front = exp_a_q.pop_front();
          a_retired++;
          if ({a_if.out_illegal, a_if.out_index, a_if.out_value} !== a_front) begin
            errors++;
            $display("FAIL a_result got=%h exp=%h", {a_if.out_illegal, a_if.out_index, a_if.out_value}, a_front);
          end
        end
      end
      if (a_if.flush) exp_a_q.delete();
      else if (a_if.in_valid && a_if.in_ready)
        exp_a_q.push_back(model_a(a_if.opcode, a_if.in_index, a_if.vt, a_if.va, a_if.vb, a_if.imm));
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      exp_b_q.delete();
    end else begin
      if (b_if.out_valid) begin
        checks++;
        if (exp_b_q.size() == 0) begin
          errors++;
          $display("FAIL b_spurious_output got idx=%0d val=%h exp=no result pending", b_if.out_index, b_if.out_value);
        end else if (b_if.out_ready) begin
          b_front = exp_b_q.pop_front();
          b_retired++;
          if ({b_if.out_illegal, b_if.out_index, b_if.out_value} !== b_front) begin
            errors++;
            $display("FAIL b_result got=%h exp=%h", {b_if.out_illegal, b_if.out_index, b_if.out_value}, b_front);
          end
        end
      end
      if (b_if.flush) exp_b_q.delete();
      else if (b_if.in_valid && b_if.in_ready)
        exp_b_q.push_back(model_b(b_if.opcode, b_if.in_index, b_if.vt, b_if.va, b_if.vb, b_if.imm));
    end
  end

  // ---------------- drivers ----------------
  // Offer one op and return 1ns after the edge that accepted it.
  task automatic issue_a(input logic [3:0] op, input logic [3:0] idx, input logic [15:0] vt,
                         input logic [15:0] va, input logic [15:0] vb, input logic [7:0] imm,
                         output int stalls);
    stalls = 0;
    a_if.in_valid = 1'b1;
    a_if.opcode   = op;
    a_if.in_index = idx;
    a_if.vt       = vt;
    a_if.va       = va;
    a_if.vb       = vb;
    a_if.imm      = imm;
    while (1) begin
      @(negedge clk);
      if (a_if.in_ready) break;
      stalls++;
      if (stalls > 200) begin
        checks++;
        errors++;
        $display("FAIL issue_a_timeout got in_ready=0 exp=1 within 200 cycles");
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    a_if.in_valid = 1'b0;
  endtask

  task automatic issue_b(input logic [3:0] op, input logic [5:0] idx, input logic [31:0] vt,
                         input logic [31:0] va, input logic [31:0] vb, input logic [15:0] imm,
                         input bit rnd_ready, output int stalls);
    stalls = 0;
    b_if.in_valid = 1'b1;
    b_if.opcode   = op;
    b_if.in_index = idx;
    b_if.vt       = vt;
    b_if.va       = va;
    b_if.vb       = vb;
    b_if.imm      = imm;
    while (1) begin
      if (rnd_ready) b_if.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (b_if.in_ready) break;
      stalls++;
      if (stalls > 200) begin
        checks++;
        errors++;
        $display("FAIL issue_b_timeout got in_ready=0 exp=1 within 200 cycles");
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    b_if.in_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    tick(3);
    checks++;
    if ({a_if.out_valid, a_if.in_ready, a_if.out_illegal, a_if.out_index, a_if.out_value} !== {1'b1 == 1'b0, 1'b1, 1'b0, 4'h0, 16'h0}) begin
      errors++;
      $display("FAIL reset_a_in_reset got=%h exp=%h", {a_if.out_valid, a_if.in_ready, a_if.out_illegal, a_if.out_index, a_if.out_value}, {1'b0, 1'b1, 1'b0, 4'h0, 16'h0});
    end
    checks++;
    if ({b_if.out_valid, b_if.in_ready, b_if.out_illegal, b_if.out_index, b_if.out_value} !== {1'b0, 1'b1, 1'b0, 6'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_b_in_reset got=%h exp=%h", {b_if.out_valid, b_if.in_ready, b_if.out_illegal, b_if.out_index, b_if.out_value}, {1'b0, 1'b1, 1'b0, 6'h0, 32'h0});
    end
    rst = 1'b0;
    tick(1);
    checks++;
    if ({a_if.out_valid, a_if.in_ready, a_if.out_illegal, a_if.out_index, a_if.out_value} !== {1'b0, 1'b1, 1'b0, 4'h0, 16'h0}) begin
      errors++;
      $display("FAIL reset_a_after_release got=%h exp=%h", {a_if.out_valid, a_if.in_ready, a_if.out_illegal, a_if.out_index, a_if.out_value}, {1'b0, 1'b1, 1'b0, 4'h0, 16'h0});
    end
  endtask

  task automatic test_basic_alu();
    int st;
    a_if.out_ready = 1'b1;
    issue_a(4'h0, 4'd3, 16'h0, 16'h0005, 16'h0003, 8'h0, st);
    checks++;
    if (a_if.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL alu_add_early got out_valid=%b exp=0", a_if.out_valid);
    end
    tick(1);
    checks++;
    if ({a_if.out_valid, a_if.out_illegal, a_if.out_index, a_if.out_value} !== {1'b1, 1'b0, 4'd3, 16'h0008}) begin
      errors++;
      $display("FAIL alu_add got=%h exp=%h", {a_if.out_valid, a_if.out_illegal, a_if.out_index, a_if.out_value}, {1'b1, 1'b0, 4'd3, 16'h0008});
    end
    issue_a(4'h1, 4'd1, 16'h0, 16'h0000, 16'h0001, 8'h0, st);
    tick(1);
    checks++;
    if ({a_if.out_valid, a_if.out_illegal, a_if.out_index, a_if.out_value} !== {1'b1, 1'b0, 4'd1, 16'hFFFF}) begin
      errors++;
      $display("FAIL alu_sub_wrap got=%h exp=%h", {a_if.out_valid, a_if.out_illegal, a_if.out_index, a_if.out_value}, {1'b1, 1'b0, 4'd1, 16'hFFFF});
    end
    issue_a(4'h4, 4'd2, 16'h0, 16'h1234, 16'h9999, 8'h0, st);
    tick(1);
    checks++;
    if ({a_if.out_valid, a_if.out_illegal, a_if.out_index, a_if.out_value} !== {1'b1, 1'b0, 4'd2, 16'h1234}) begin
      errors++;
      $display("FAIL alu_mov got=%h exp=%h", {a_if.out_valid, a_if.out_illegal, a_if.out_index, a_if.out_value}, {1'b1, 1'b0, 4'd2, 16'h1234});
    end
    tick(2);
  endtask

  task automatic test_imm_moves();
    logic [3:0]  ops  [3] = '{4'h5, 4'h6, 4'hF};
    logic [15:0] vals [3] = '{16'hAB12, 16'h12CD, 16'h0000};
    logic        ills [3] = '{1'b0, 1'b0, 1'b1};
    int st;
    a_if.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue_a(ops[i], 4'(9 + i), 16'hABCD, 16'h5555, 16'h3333, 8'h12, st);
      tick(1);
      checks++;
      if ({a_if.out_valid, a_if.out_illegal, a_if.out_index, a_if.out_value} !== {1'b1, ills[i], 4'(9 + i), vals[i]}) begin
        errors++;
        $display("FAIL imm_op%h got=%h exp=%h", ops[i], {a_if.out_valid, a_if.out_illegal, a_if.out_index, a_if.out_value}, {1'b1, ills[i], 4'(9 + i), vals[i]});
      end
    end
    tick(2);
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops [6] = '{4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'hA};
    int st;
    int total = 0;
    int r0;
    a_if.out_ready = 1'b1;
    r0 = a_retired;
    for (int i = 0; i < 8; i++) begin
      issue_a(ops[$urandom_range(0, 5)], 4'(i), 16'($urandom()), 16'($urandom()), 16'($urandom()), 8'($urandom()), st);
      total += st;
    end
    tick(4);
    checks++;
    if (total !== 0) begin
      errors++;
      $display("FAIL b2b_stalls got=%0d exp=0", total);
    end
    checks++;
    if (a_retired - r0 !== 8) begin
      errors++;
      $display("FAIL b2b_retired got=%0d exp=8", a_retired - r0);
    end
  endtask

  task automatic test_backpressure();
    int st;
    int r0;
    a_if.out_ready = 1'b1;
    r0 = a_retired;
    issue_a(4'h0, 4'd0, 16'h0, 16'h0100, 16'h0001, 8'h0, st);
    // idx1 goes in while the output slot is still empty; ROB stops taking results
    a_if.out_ready = 1'b0;
    a_if.in_valid  = 1'b1;
    a_if.in_index  = 4'd1;
    a_if.va        = 16'h0200;
    a_if.vb        = 16'h0002;
    tick(1);
    a_if.in_index  = 4'd2;
    a_if.va        = 16'h0300;
    a_if.vb        = 16'h0003;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({a_if.out_valid, a_if.in_ready, a_if.out_illegal, a_if.out_index, a_if.out_value} !== {1'b1, 1'b0, 1'b0, 4'd0, 16'h0101}) begin
        errors++;
        $display("FAIL bp_hold_%0d got=%h exp=%h", i, {a_if.out_valid, a_if.in_ready, a_if.out_illegal, a_if.out_index, a_if.out_value}, {1'b1, 1'b0, 1'b0, 4'd0, 16'h0101});
      end
      tick(1);
    end
    a_if.out_ready = 1'b1;
    issue_a(4'h0, 4'd2, 16'h0, 16'h0300, 16'h0003, 8'h0, st);
    issue_a(4'h0, 4'd3, 16'h0, 16'h0400, 16'h0004, 8'h0, st);
    tick(4);
    checks++;
    if ((a_retired - r0) !== 4 || exp_a_q.size() !== 0) begin
      errors++;
      $display("FAIL bp_drain got retired=%0d pending=%0d exp retired=4 pending=0", a_retired - r0, exp_a_q.size());
    end
  endtask

  task automatic test_flush();
    int st;
    int r0;
    a_if.out_ready = 1'b1;
    r0 = a_retired;
    issue_a(4'h0, 4'd5, 16'h0, 16'h0005, 16'h0005, 8'h0, st);
    issue_a(4'h0, 4'd6, 16'h0, 16'h0006, 16'h0006, 8'h0, st);
    // idx5 is at the output and retires this cycle; idx6 and idx7 must die
    a_if.in_valid = 1'b1;
    a_if.in_index = 4'd7;
    a_if.flush    = 1'b1;
    tick(1);
    a_if.flush    = 1'b0;
    a_if.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (a_if.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_quiet_%0d got out_valid=%b idx=%0d exp=0", i, a_if.out_valid, a_if.out_index);
      end
      tick(1);
    end
    checks++;
    if ((a_retired - r0) !== 1) begin
      errors++;
      $display("FAIL flush_retired got=%0d exp=1", a_retired - r0);
    end
    issue_a(4'h0, 4'd8, 16'h0, 16'h0010, 16'h0020, 8'h0, st);
    tick(1);
    checks++;
    if ({a_if.out_valid, a_if.out_illegal, a_if.out_index, a_if.out_value} !== {1'b1, 1'b0, 4'd8, 16'h0030}) begin
      errors++;
      $display("FAIL flush_next_op got=%h exp=%h", {a_if.out_valid, a_if.out_illegal, a_if.out_index, a_if.out_value}, {1'b1, 1'b0, 4'd8, 16'h0030});
    end
    tick(2);
  endtask

  task automatic test_reset_midflight();
    int st;
    int r0;
    a_if.out_ready = 1'b1;
    r0 = a_retired;
    issue_a(4'h0, 4'd10, 16'h0, 16'h1111, 16'h1111, 8'h0, st);
    issue_a(4'h1, 4'd11, 16'h0, 16'h3333, 16'h1111, 8'h0, st);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({a_if.out_valid, a_if.in_ready, a_if.out_illegal, a_if.out_index, a_if.out_value} !== {1'b0, 1'b1, 1'b0, 4'h0, 16'h0}) begin
      errors++;
      $display("FAIL rst_mid_outputs got=%h exp=%h", {a_if.out_valid, a_if.in_ready, a_if.out_illegal, a_if.out_index, a_if.out_value}, {1'b0, 1'b1, 1'b0, 4'h0, 16'h0});
    end
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checks++;
      if (a_if.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_quiet_%0d got out_valid=%b exp=0", i, a_if.out_valid);
      end
    end
    checks++;
    if (a_retired !== r0) begin
      errors++;
      $display("FAIL rst_mid_retired got=%0d exp=0", a_retired - r0);
    end
    issue_a(4'h4, 4'd12, 16'h0, 16'h7777, 16'h0, 8'h0, st);
    tick(1);
    checks++;
    if ({a_if.out_valid, a_if.out_illegal, a_if.out_index, a_if.out_value} !== {1'b1, 1'b0, 4'd12, 16'h7777}) begin
      errors++;
      $display("FAIL rst_mid_next_op got=%h exp=%h", {a_if.out_valid, a_if.out_illegal, a_if.out_index, a_if.out_value}, {1'b1, 1'b0, 4'd12, 16'h7777});
    end
    tick(2);
  endtask

  task automatic test_sweep();
    logic [3:0] ops [6] = '{4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'h9};
    int st;
    int total = 0;
    int r0;
    b_if.out_ready = 1'b1;
    r0 = b_retired;
    issue_b(4'h0, 6'd33, 32'h0, 32'hFFFF_FFFF, 32'h0000_0001, 16'h0, 1'b0, st);
    checks++;
    if ({b_if.out_valid, b_if.out_illegal, b_if.out_index, b_if.out_value} !== {1'b1, 1'b0, 6'd33, 32'h0}) begin
      errors++;
      $display("FAIL sweep_add_wrap got=%h exp=%h", {b_if.out_valid, b_if.out_illegal, b_if.out_index, b_if.out_value}, {1'b1, 1'b0, 6'd33, 32'h0});
    end
    // Full-rate with the ROB always ready
    for (int i = 0; i < 8; i++) begin
      issue_b(ops[$urandom_range(0, 5)], 6'(i), $urandom(), $urandom(), $urandom(), 16'($urandom()), 1'b0, st);
      total += st;
    end
    checks++;
    if (total !== 0) begin
      errors++;
      $display("FAIL sweep_full_rate_stalls got=%0d exp=0", total);
    end
    // Streaming with random ROB backpressure
    for (int i = 0; i < 64; i++) begin
      issue_b(ops[$urandom_range(0, 5)], 6'(i), $urandom(), $urandom(), $urandom(), 16'($urandom()), 1'b1, st);
    end
    b_if.out_ready = 1'b1;
    for (int n = 0; n < 50 && exp_b_q.size() != 0; n++) tick(1);
    tick(2);
    checks++;
    if ((b_retired - r0) !== 73 || exp_b_q.size() !== 0) begin
      errors++;
      $display("FAIL sweep_drain got retired=%0d pending=%0d exp retired=73 pending=0", b_retired - r0, exp_b_q.size());
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst = 1'b1;
    a_if.in_valid = 1'b0; a_if.opcode = 4'h0; a_if.in_index = '0; a_if.vt = '0; a_if.va = '0;
    a_if.vb = '0; a_if.imm = '0; a_if.flush = 1'b0; a_if.out_ready = 1'b1;
    b_if.in_valid = 1'b0; b_if.opcode = 4'h0; b_if.in_index = '0; b_if.vt = '0; b_if.va = '0;
    b_if.vb = '0; b_if.imm = '0; b_if.flush = 1'b0; b_if.out_ready = 1'b1;
    #1;
    test_reset();
    test_basic_alu();
    test_imm_moves();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_midflight();
    test_sweep();
    checks++;
    if (exp_a_q.size() !== 0) begin
      errors++;
      $display("FAIL final_a_pending got=%0d exp=0", exp_a_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

●
